// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : uart_pkg
//  Description : Shared types and helpers for the parametrised UART receiver.
//                Provides the parity-mode enum, the receiver FSM state enum
//                and the expected-parity helper uart_par().
//  Revision    : 1.0 - initial release
// ============================================================================
package uart_pkg;

    // Widest supported data word; the parity helper works on this width and
    // narrower words are zero-extended, which leaves the XOR unchanged.
    localparam int c_MAX_DATA_BITS = 9;

    // Bit counter width: wide enough for up to c_MAX_DATA_BITS data samples.
    localparam int c_BIT_CNT_W = 4;

    typedef enum logic [1:0] {
        PAR_NONE = 2'd0,
        PAR_EVEN = 2'd1,
        PAR_ODD  = 2'd2
    } parity_t;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_START   = 3'd1,
        ST_DATA    = 3'd2,
        ST_PAR     = 3'd3,
        ST_STOP    = 3'd4,
        ST_WAIT_HI = 3'd5
    } rx_state_t;

    // Expected value of the parity bit for a data word.
    // Even: data ^ parity must XOR to 0, so the bit equals ^data.
    // Odd : data ^ parity must XOR to 1, so the bit equals ~^data.
    function automatic logic uart_par(input logic [c_MAX_DATA_BITS-1:0] data,
                                      input parity_t mode);
        case (mode)
            PAR_EVEN: return ^data;
            PAR_ODD:  return ~^data;
            default:  return 1'b0;
        endcase
    endfunction

endpackage : uart_pkg
`default_nettype wire

// File: rtl/uart_rx_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : uart_rx_fifo
//  Description : Small synchronous FIFO holding received words.
//                Pointers carry one extra wrap bit: equal pointers mean
//                empty, equal address with differing MSB means full.
//                A push while full is accepted only when a pop happens in
//                the same cycle (the pop frees the slot first).
//  Ports       : clk   - clock (rising edge)
//                rst   - asynchronous active-low reset (flushes the FIFO)
//                push  - write din this cycle
//                din   - word to write
//                full  - no free entry
//                pop   - discard the head entry this cycle
//                dout  - head entry (forced to 0 while empty)
//                empty - no stored entry
//  Revision    : 1.0 - initial release
// ============================================================================
module uart_rx_fifo
    import uart_pkg::*;
#(
    parameter int WIDTH = 10,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    output logic             full,
    input  logic             pop,
    output logic [WIDTH-1:0] dout,
    output logic             empty
);

    localparam int c_AW = $clog2(DEPTH);

    logic [c_AW:0]      r_wptr;
    logic [c_AW:0]      r_rptr;
    logic [WIDTH-1:0]   r_mem [DEPTH];
    logic               w_rd;
    logic               w_wr;

    assign empty = (r_wptr == r_rptr);
    assign full  = (r_wptr[c_AW] != r_rptr[c_AW]) &&
                   (r_wptr[c_AW-1:0] == r_rptr[c_AW-1:0]);

    assign w_rd = pop & ~empty;
    assign w_wr = push & (~full | w_rd);

    // Gating the head with empty keeps the output at 0 after reset without
    // having to reset the storage array.
    assign dout = empty ? '0 : r_mem[r_rptr[c_AW-1:0]];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wptr <= '0;
            r_rptr <= '0;
        end else begin
            if (w_wr) begin
                r_wptr <= r_wptr + (c_AW+1)'(1);
            end
            if (w_rd) begin
                r_rptr <= r_rptr + (c_AW+1)'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_wr) begin
            r_mem[r_wptr[c_AW-1:0]] <= din;
        end
    end

endmodule : uart_rx_fifo
`default_nettype wire

// File: rtl/uart_rx_param.sv
`default_nettype none
// ============================================================================
//  Module      : uart_rx_param
//  Description : Parametrised UART receiver with input synchroniser,
//                3-sample majority voting, false-start rejection, optional
//                parity, 1 or 2 stop bits and an output FIFO read over a
//                valid/ready handshake.
//  Ports       : clk        - clock (rising edge)
//                rst        - asynchronous active-low reset
//                rxd        - serial input, asynchronous, idles high
//                data       - head-of-FIFO word, LSB = first bit received
//                valid      - FIFO non-empty; data/frame_err/parity_err valid
//                ready      - consumer accepts head; pop on valid & ready
//                frame_err  - head word had a low stop bit
//                parity_err - head word failed its parity check
//                overrun    - one-cycle pulse when a frame is dropped (full)
//  Revision    : 1.0 - initial release
// ============================================================================
module uart_rx_param
    import uart_pkg::*;
#(
    parameter int DIV        = 234,
    parameter int DATA_BITS  = 8,
    parameter int PARITY     = 0,
    parameter int STOP_BITS  = 1,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 rxd,
    output logic [DATA_BITS-1:0] data,
    output logic                 valid,
    input  logic                 ready,
    output logic                 frame_err,
    output logic                 parity_err,
    output logic                 overrun
);

    localparam int                c_CW       = $clog2(DIV);
    localparam int                c_WW       = DATA_BITS + 2;
    localparam logic [c_CW-1:0]   c_HALF     = c_CW'(DIV / 2 - 1);
    localparam logic [c_CW-1:0]   c_LAST     = c_CW'(DIV - 1);
    localparam parity_t           c_PAR_MODE = parity_t'(2'(PARITY));
    localparam logic [c_BIT_CNT_W-1:0] c_DLAST = c_BIT_CNT_W'(DATA_BITS - 1);
    localparam logic [c_BIT_CNT_W-1:0] c_SLAST = c_BIT_CNT_W'(STOP_BITS - 1);

    // ------------------------------------------------------------------
    // Synchroniser and majority vote
    // ------------------------------------------------------------------
    logic       r_sync1;
    logic       r_rxs;
    logic [2:0] r_hist;
    logic       w_vote;
    logic       w_fall;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_sync1 <= 1'b1;
            r_rxs   <= 1'b1;
            r_hist  <= 3'b111;
        end else begin
            r_sync1 <= rxd;
            r_rxs   <= r_sync1;
            r_hist  <= {r_hist[1:0], r_rxs};
        end
    end

    assign w_vote = (r_hist[0] & r_hist[1]) |
                    (r_hist[0] & r_hist[2]) |
                    (r_hist[1] & r_hist[2]);

    // r_hist[0] is the previous synchronised value.
    assign w_fall = r_hist[0] & ~r_rxs;

    // ------------------------------------------------------------------
    // Receive FSM
    // ------------------------------------------------------------------
    rx_state_t              r_state;
    logic [c_CW-1:0]        r_cnt;
    logic [c_BIT_CNT_W-1:0] r_bit;
    logic [DATA_BITS-1:0]   r_shift;
    logic                   r_ferr;
    logic                   r_perr;
    logic                   r_push;
    logic [c_WW-1:0]        r_word;
    logic                   w_tick;
    logic                   w_ferr_now;

    assign w_tick     = (r_cnt == c_LAST);
    // Frame error including the stop sample being taken this cycle.
    assign w_ferr_now = r_ferr | ~w_vote;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_bit   <= '0;
            r_shift <= '0;
            r_ferr  <= 1'b0;
            r_perr  <= 1'b0;
            r_push  <= 1'b0;
            r_word  <= '0;
        end else begin
            r_push <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_fall) begin
                        r_cnt   <= '0;
                        r_state <= ST_START;
                    end
                end

                ST_START: begin
                    if (r_cnt == c_HALF) begin
                        // Mid-start: a high vote means the low was a glitch.
                        r_cnt   <= '0;
                        r_bit   <= '0;
                        r_ferr  <= 1'b0;
                        r_perr  <= 1'b0;
                        r_state <= w_vote ? ST_IDLE : ST_DATA;
                    end else begin
                        r_cnt <= r_cnt + c_CW'(1);
                    end
                end

                ST_DATA: begin
                    if (w_tick) begin
                        r_cnt   <= '0;
                        r_shift <= {w_vote, r_shift[DATA_BITS-1:1]};
                        if (r_bit == c_DLAST) begin
                            r_bit   <= '0;
                            r_state <= (c_PAR_MODE == PAR_NONE) ? ST_STOP : ST_PAR;
                        end else begin
                            r_bit <= r_bit + c_BIT_CNT_W'(1);
                        end
                    end else begin
                        r_cnt <= r_cnt + c_CW'(1);
                    end
                end

                ST_PAR: begin
                    if (w_tick) begin
                        r_cnt <= '0;
                        if (w_vote != uart_par(c_MAX_DATA_BITS'(r_shift), c_PAR_MODE)) begin
                            r_perr <= 1'b1;
                        end
                        r_state <= ST_STOP;
                    end else begin
                        r_cnt <= r_cnt + c_CW'(1);
                    end
                end

                ST_STOP: begin
                    if (w_tick) begin
                        r_cnt  <= '0;
                        r_ferr <= w_ferr_now;
                        if (r_bit == c_SLAST) begin
                            r_bit   <= '0;
                            r_push  <= 1'b1;
                            r_word  <= {w_ferr_now, r_perr, r_shift};
                            // A low final stop means the line may be in break;
                            // wait for it to go high before re-arming.
                            r_state <= w_vote ? ST_IDLE : ST_WAIT_HI;
                        end else begin
                            r_bit <= r_bit + c_BIT_CNT_W'(1);
                        end
                    end else begin
                        r_cnt <= r_cnt + c_CW'(1);
                    end
                end

                ST_WAIT_HI: begin
                    if (r_rxs) begin
                        r_state <= ST_IDLE;
                    end
                end

                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Output FIFO and overrun
    // ------------------------------------------------------------------
    logic            w_full;
    logic            w_empty;
    logic            w_pop;
    logic [c_WW-1:0] w_head;
    logic            r_overrun;

    assign w_pop = ~w_empty & ready;

    uart_rx_fifo #(
        .WIDTH (c_WW),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (r_push),
        .din   (r_word),
        .full  (w_full),
        .pop   (w_pop),
        .dout  (w_head),
        .empty (w_empty)
    );

    // A same-cycle pop frees a slot, so only a push into a full FIFO with
    // no pop is dropped.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_overrun <= 1'b0;
        end else begin
            r_overrun <= r_push & w_full & ~w_pop;
        end
    end

    assign {frame_err, parity_err, data} = w_head;
    assign valid   = ~w_empty;
    assign overrun = r_overrun;

endmodule : uart_rx_param
`default_nettype wire

// File: tb/tb_uart_rx_param.sv
`default_nettype none
// ============================================================================
//  Module      : tb_uart_rx_param
//  Description : Self-checking bench for uart_rx_param. Three instances:
//                A = 8N1, B = 8E1, C = 7N2, all with DIV = 16.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_rx_param;
    import uart_pkg::*;

    localparam int DIV = 16;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    logic       rxd_a = 1'b1, ready_a = 1'b1;
    logic       valid_a, fe_a, pe_a, ovr_a;
    logic [7:0] data_a;
    logic       rxd_b = 1'b1, ready_b = 1'b1;
    logic       valid_b, fe_b, pe_b, ovr_b;
    logic [7:0] data_b;
    logic       rxd_c = 1'b1, ready_c = 1'b1;
    logic       valid_c, fe_c, pe_c, ovr_c;
    logic [6:0] data_c;

    uart_rx_param #(.DIV(DIV), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1), .FIFO_DEPTH(4)) dut_a (
        .clk(clk), .rst(rst), .rxd(rxd_a), .data(data_a), .valid(valid_a), .ready(ready_a),
        .frame_err(fe_a), .parity_err(pe_a), .overrun(ovr_a));
    uart_rx_param #(.DIV(DIV), .DATA_BITS(8), .PARITY(1), .STOP_BITS(1), .FIFO_DEPTH(4)) dut_b (
        .clk(clk), .rst(rst), .rxd(rxd_b), .data(data_b), .valid(valid_b), .ready(ready_b),
        .frame_err(fe_b), .parity_err(pe_b), .overrun(ovr_b));
    uart_rx_param #(.DIV(DIV), .DATA_BITS(7), .PARITY(0), .STOP_BITS(2), .FIFO_DEPTH(4)) dut_c (
        .clk(clk), .rst(rst), .rxd(rxd_c), .data(data_c), .valid(valid_c), .ready(ready_c),
        .frame_err(fe_c), .parity_err(pe_c), .overrun(ovr_c));

    typedef struct {
        logic [8:0] d;
        logic       fe;
        logic       pe;
    } word_t;

    typedef struct {
        int         inst;
        logic [8:0] d;
        logic       pbit;
        logic       stop_last;
        int         hold;
        logic [8:0] ed;
        logic       efe;
        logic       epe;
    } vec_t;

    word_t qa[$], qb[$], qc[$];
    int    rise_q[$];
    int    ovr_cnt = 0;
    logic  pv_a = 1'b0;
    int    n_tests = 0;
    int    n_fail  = 0;

    // Capture every popped word and the cycle at which valid_a rises.
    always @(negedge clk) begin
        if (rst) begin
            if (valid_a && ready_a) qa.push_back('{9'(data_a), fe_a, pe_a});
            if (valid_b && ready_b) qb.push_back('{9'(data_b), fe_b, pe_b});
            if (valid_c && ready_c) qc.push_back('{9'(data_c), fe_c, pe_c});
            if (valid_a && !pv_a) rise_q.push_back(cyc);
            if (ovr_a) ovr_cnt++;
        end
        pv_a = valid_a;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic set_rxd(input int inst, input logic v);
        case (inst)
            0:       rxd_a = v;
            1:       rxd_b = v;
            default: rxd_c = v;
        endcase
    endtask

    function automatic int qsize(input int inst);
        case (inst)
            0:       return qa.size();
            1:       return qb.size();
            default: return qc.size();
        endcase
    endfunction

    function automatic word_t qpop(input int inst);
        case (inst)
            0:       return qa.pop_front();
            1:       return qb.pop_front();
            default: return qc.pop_front();
        endcase
    endfunction

    task automatic flush_q();
        qa.delete();
        qb.delete();
        qc.delete();
    endtask

    // Send one frame on an instance; framing follows that instance's config.
    // t0 is the cycle counter value when the start bit was driven low.
    task automatic send(input int inst, input logic [8:0] d, input logic pbit,
                        input logic stop_last, input int hold, output int t0);
        int nb;
        int ns;
        nb = (inst == 2) ? 7 : 8;
        ns = (inst == 2) ? 2 : 1;
        @(posedge clk); #1;
        t0 = cyc;
        set_rxd(inst, 1'b0);
        repeat (DIV) @(posedge clk);
        #1;
        for (int i = 0; i < nb; i++) begin
            set_rxd(inst, d[i]);
            repeat (DIV) @(posedge clk);
            #1;
        end
        if (inst == 1) begin
            set_rxd(inst, pbit);
            repeat (DIV) @(posedge clk);
            #1;
        end
        for (int s = 0; s < ns; s++) begin
            set_rxd(inst, (s == ns - 1) ? stop_last : 1'b1);
            repeat (DIV) @(posedge clk);
            #1;
        end
        if (hold > 0) begin
            repeat (hold) @(posedge clk);
            #1;
        end
        set_rxd(inst, 1'b1);
    endtask

    task automatic check_word(input string name, input int inst, input logic [8:0] ed,
                              input logic efe, input logic epe);
        word_t w;
        if (qsize(inst) == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL %s: got no word, expected data 0x%0h", name, ed);
        end else begin
            w = qpop(inst);
            check({name, "_data"}, 32'(w.d), 32'(ed));
            check({name, "_fe"}, 32'(w.fe), 32'(efe));
            check({name, "_pe"}, 32'(w.pe), 32'(epe));
        end
    endtask

    vec_t vt[10];
    int   t0a, t0b;

    initial begin
        //          inst d       pbit  stop  hold     ed      fe    pe
        vt[0] = '{0, 9'h000, 1'b0, 1'b1, 0,       9'h000, 1'b0, 1'b0};
        vt[1] = '{0, 9'h0FF, 1'b0, 1'b1, 0,       9'h0FF, 1'b0, 1'b0};
        vt[2] = '{1, 9'h007, 1'b0, 1'b1, 0,       9'h007, 1'b0, 1'b1};
        vt[3] = '{1, 9'h007, 1'b1, 1'b1, 0,       9'h007, 1'b0, 1'b0};
        vt[4] = '{1, 9'h000, 1'b1, 1'b1, 0,       9'h000, 1'b0, 1'b1};
        vt[5] = '{1, 9'h0FF, 1'b0, 1'b1, 0,       9'h0FF, 1'b0, 1'b0};
        vt[6] = '{2, 9'h07F, 1'b0, 1'b1, 0,       9'h07F, 1'b0, 1'b0};
        vt[7] = '{2, 9'h02A, 1'b0, 1'b0, 0,       9'h02A, 1'b1, 1'b0};
        vt[8] = '{0, 9'h081, 1'b0, 1'b0, 3 * DIV, 9'h081, 1'b1, 1'b0};
        vt[9] = '{1, 9'h05A, 1'b0, 1'b0, 0,       9'h05A, 1'b1, 1'b0};

        // ---------------- reset state ----------------
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_valid_a", 32'(valid_a), 0);
        check("rst_data_a", 32'(data_a), 0);
        check("rst_errs_a", 32'({fe_a, pe_a, ovr_a}), 0);
        check("rst_valid_bc", 32'({valid_b, valid_c}), 0);
        check("rst_data_c", 32'(data_c), 0);
        rst = 1'b1;
        repeat (4) @(posedge clk);
        @(negedge clk);
        check("post_rst_valid", 32'({valid_a, valid_b, valid_c}), 0);
        check("post_rst_state", 32'(dut_a.r_state), 32'(ST_IDLE));

        // ---------------- back-to-back 8N1 with valid timing ----------------
        rise_q.delete();
        flush_q();
        send(0, 9'h055, 1'b0, 1'b1, 0, t0a);
        send(0, 9'h0A3, 1'b0, 1'b1, 0, t0b);
        repeat (2 * DIV) @(posedge clk);
        check("b2b_rise_count", 32'(rise_q.size()), 2);
        if (rise_q.size() == 2) begin
            check("b2b_rise0", 32'(rise_q[0]), 32'(t0a + 4 + DIV / 2 + 9 * DIV));
            check("b2b_rise1", 32'(rise_q[1]), 32'(t0b + 4 + DIV / 2 + 9 * DIV));
        end
        check("b2b_count", 32'(qa.size()), 2);
        check_word("b2b_w0", 0, 9'h055, 1'b0, 1'b0);
        check_word("b2b_w1", 0, 9'h0A3, 1'b0, 1'b0);

        // ---------------- table of single frames ----------------
        for (int i = 0; i < 10; i++) begin
            flush_q();
            send(vt[i].inst, vt[i].d, vt[i].pbit, vt[i].stop_last, vt[i].hold, t0a);
            repeat (3 * DIV) @(posedge clk);
            check($sformatf("v%0d_count", i), 32'(qsize(vt[i].inst)), 1);
            check_word($sformatf("v%0d", i), vt[i].inst, vt[i].ed, vt[i].efe, vt[i].epe);
        end

        // ---------------- glitch rejection ----------------
        flush_q();
        @(posedge clk); #1;
        rxd_a = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        rxd_a = 1'b1;
        repeat (7) @(posedge clk);
        @(negedge clk);
        check("glitch_idle", 32'(dut_a.r_state), 32'(ST_IDLE));
        repeat (12 * DIV) @(posedge clk);
        check("glitch_noword", 32'(qa.size()), 0);

        // ---------------- FIFO fill and overrun ----------------
        flush_q();
        ovr_cnt = 0;
        ready_a = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            send(0, 9'(i), 1'b0, 1'b1, 0, t0a);
            repeat (DIV) @(posedge clk);
        end
        @(negedge clk);
        check("ovr_none_yet", 32'(ovr_cnt), 0);
        check("ovr_head_hold", 32'({valid_a, data_a}), 32'({1'b1, 8'h01}));
        send(0, 9'h005, 1'b0, 1'b1, 0, t0a);
        repeat (2 * DIV) @(posedge clk);
        @(negedge clk);
        check("ovr_pulse", 32'(ovr_cnt), 1);
        check("ovr_head_kept", 32'(data_a), 32'h01);
        ready_a = 1'b1;
        repeat (8) @(posedge clk);
        check("ovr_count", 32'(qa.size()), 4);
        for (int i = 1; i <= 4; i++) begin
            check_word($sformatf("ovr_w%0d", i), 0, 9'(i), 1'b0, 1'b0);
        end

        // ---------------- reset mid-frame flushes and aborts ----------------
        flush_q();
        ready_a = 1'b0;
        send(0, 9'h011, 1'b0, 1'b1, 0, t0a);
        repeat (DIV) @(posedge clk);
        @(negedge clk);
        check("rstmid_pre_valid", 32'(valid_a), 1);
        fork
            begin
                send(0, 9'h0F0, 1'b0, 1'b1, 0, t0b);
            end
            begin
                repeat (100) @(posedge clk);
                #2;
                rst = 1'b0;
                repeat (2) @(posedge clk);
                #2;
                rst = 1'b1;
            end
        join
        repeat (2 * DIV) @(posedge clk);
        @(negedge clk);
        check("rstmid_flushed", 32'(valid_a), 0);
        ready_a = 1'b1;
        repeat (4) @(posedge clk);
        check("rstmid_noword", 32'(qa.size()), 0);
        send(0, 9'h03C, 1'b0, 1'b1, 0, t0a);
        repeat (2 * DIV) @(posedge clk);
        check("rstmid_after_count", 32'(qa.size()), 1);
        check_word("rstmid_after", 0, 9'h03C, 1'b0, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule : tb_uart_rx_param
`default_nettype wire

// File: doc/uart_rx_param.md
# uart_rx_param

Parametrised UART receiver; the successor to the fixed 8N1 `uartrx`, which has a single `div` parameter. It adds configurable data width, parity and stop bits, an input synchroniser and 3-sample majority voting. It rejects false starts and reports framing and parity errors per word. Received words go into a small output FIFO read over a valid/ready handshake. It sits between the board `rxd` pin and any consumer logic, such as the LED/debug wrappers or command decoders.

## Interface
- `DIV`, 234: clocks per bit, minimum 8. 234 gives 115200 baud at 27 MHz.
- `DATA_BITS`, 8: data bits per frame, range 5..9.
- `PARITY`, 0: 0 = none, 1 = even, 2 = odd.
- `STOP_BITS`, 1: 1 or 2.
- `FIFO_DEPTH`, 4: output FIFO entries, power of two, at least 2.
- `clk` in 1: single clock; all logic is on the rising edge.
- `rst` in 1: asynchronous, active-low reset.
- `rxd` in 1: serial input, asynchronous to `clk`, idles high.
- `data` out DATA_BITS: head-of-FIFO word, LSB = first bit received.
- `valid` out 1: FIFO is non-empty, so `data`/`frame_err`/`parity_err` are valid.
- `ready` in 1: consumer accepts the head; a pop happens when `valid & ready`.
- `frame_err` out 1: the head word had a low stop bit.
- `parity_err` out 1: the head word failed its parity check; always 0 when PARITY = 0.
- `overrun` out 1: one-cycle pulse when a completed frame is dropped because the FIFO is full.

## Operation
- Synchroniser: two flops, both reset to 1, giving `rxs`. A 3-bit history holds the last three `rxs` values. `vote` is the majority of those three bits.
- Baud counter: width clog2(DIV), reset to 0. Bit counter counts data and stop bits. All sample points are multiples of DIV clocks after mid-start.
- FSM states: IDLE, START, DATA, PAR, STOP, WAIT_HI.
  - IDLE: a falling edge on `rxs` (1→0) clears the counter and moves to START.
  - START: at count DIV/2−1, if `vote` = 1 it is a false start and the FSM returns to IDLE; otherwise it clears the counter and moves to DATA.
  - DATA: at count DIV−1, shift `vote` into the top of the shift register (LSB first). After DATA_BITS samples, go to PAR if PARITY ≠ 0, else to STOP.
  - PAR: sample once and compare. Even parity requires XOR(data, parity bit) = 0; odd requires it to be 1. A mismatch sets the pending `parity_err`.
  - STOP: sample STOP_BITS times. Any sample of 0 sets the pending `frame_err`.
  - Push point: after the last stop sample, the word is pushed together with both error bits in that same cycle. The FSM then goes to IDLE if the last stop sample was 1, or to WAIT_HI if it was 0.
  - WAIT_HI: stay until `rxs` = 1, then go to IDLE. This prevents a break condition (line held low) from retriggering the receiver.
- FIFO: entries are {frame_err, parity_err, data}. A push while full drops the new frame, pulses `overrun` for one cycle, and leaves the stored contents unchanged.
  - Push and pop in the same cycle while full: the pop is taken first, so the push succeeds and there is no overrun.
  - Push and pop in the same cycle while empty: not possible, because `valid` is 0.
- Outputs: `data`, `frame_err` and `parity_err` are don't-care while `valid` = 0. They must not change while `valid & !ready`.

## Timing
- Reset values: FSM = IDLE, counters = 0, FIFO empty, `valid` = 0, `data` = 0, `frame_err` = `parity_err` = `overrun` = 0.
- Reset asserted mid-frame aborts the frame and flushes the FIFO. After release, the receiver waits for a fresh falling edge.
- `rxd` to `rxs` latency is 2 clocks. Start detection occurs 3 clocks after the `rxd` falling edge.
- Push happens at cycle P (the last stop sample). `valid` rises at P+1 if the FIFO was empty.
- Pop on edge T: the next entry appears at T+1. `valid` falls at T+1 if that pop emptied the FIFO.
- Back-to-back frames: a new start edge is accepted the cycle after returning to IDLE. Stop-bit timing therefore tolerates about half a bit of transmitter drift.

## Structure
- Shared package `uart_pkg`: parity enum (NONE/EVEN/ODD), FSM state enum, and a helper function `uart_par(data, mode)`.
- Sub-module `uart_rx_fifo`: a synchronous FIFO parametrised on width and depth with `push`/`full`/`pop`/`empty`. Its pointers are one bit wider than the address, with wrap-around by MSB compare. The rest (synchroniser, FSM, counters, overrun logic) lives in `uart_rx_param`.

## Test plan
Benches use DIV = 16 unless stated otherwise.
- 8N1, send 0x55 then 0xA3 with `ready` = 1 → two words 0x55 and 0xA3, no errors, `valid` rises P+1 after each last stop sample.
- PARITY = 1 (even), send 0x07 with parity bit 0 (wrong) → `data` = 0x07, `parity_err` = 1. Resend with parity bit 1 → `parity_err` = 0.
- Stop bit forced low, `rxd` held low for 3 bit times, then released → `frame_err` = 1, exactly one word, and no retrigger until `rxd` returns high.
- Glitch: `rxd` low for 4 clocks → no push, FSM back in IDLE by start + DIV/2 + 3 clocks.
- FIFO_DEPTH = 4, `ready` = 0, send 0x01..0x05 → a single `overrun` pulse at the 5th push. Then `ready` = 1 reads 0x01..0x04 in order.
- Reset pulsed during DATA of one frame → no output. A following clean 0x3C frame is received correctly. DATA_BITS = 7, STOP_BITS = 2 reception of 0x7F passes.
